// File: rtl/reg_bus_arbiter.sv
// Round-robin sequencer for two requesters sharing an 8-entry register switch.
// Drives the switch sel/dir, owns the out-side bus for writes and inserts turnaround gaps on dir changes.
module reg_bus_arbiter #(
    parameter int DW       = 8,
    parameter int AW       = 3,
    parameter int TURN_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ack,
    output logic [DW-1:0] b_rdata,
    output logic [AW-1:0] sw_sel,
    output logic          sw_dir,
    output logic [DW-1:0] bus_out,
    output logic          bus_oe,
    input  logic [DW-1:0] bus_in,
    output logic          busy
);
    typedef enum logic [2:0] {IDLE, SETUP, TURN, XFER, ACK} state_t;
    localparam logic GNT_A = 1'b0;
    localparam logic GNT_B = 1'b1;

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic          gnt_q, gnt_d;
    logic          wr_q, wr_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [AW-1:0] sw_sel_q, sw_sel_d;
    logic          sw_dir_q, sw_dir_d;
    logic [DW-1:0] bus_out_q, bus_out_d;
    logic          bus_oe_q, bus_oe_d;
    logic          a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic          busy_q, busy_d;
    logic          win;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        sw_sel_d   = sw_sel_q;
        sw_dir_d   = sw_dir_q;
        bus_out_d  = bus_out_q;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        win        = GNT_A;

        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    // On a tie the requester that was not served last wins.
                    win        = (a_req && b_req) ? ~last_gnt_q : b_req;
                    gnt_d      = win;
                    last_gnt_d = win;
                    wr_d       = win ? b_wr    : a_wr;
                    addr_d     = win ? b_addr  : a_addr;
                    wdata_d    = win ? b_wdata : a_wdata;
                    sw_sel_d   = win ? b_addr  : a_addr;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (wr_q == sw_dir_q) begin
                    state_d = XFER;
                end else begin
                    cnt_d    = 3'(TURN_CYC);
                    sw_dir_d = wr_q;
                    state_d  = TURN;
                end
            end
            TURN: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = XFER;
            end
            XFER: begin
                state_d = ACK;
                if (!wr_q) begin
                    if (gnt_q == GNT_B) b_rdata_d = bus_in;
                    else                a_rdata_d = bus_in;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Registered outputs are derived from the state being entered.
        bus_oe_d = (state_d == XFER) && wr_q;
        if (bus_oe_d) bus_out_d = wdata_q;
        a_ack_d = (state_d == ACK) && (gnt_q == GNT_A);
        b_ack_d = (state_d == ACK) && (gnt_q == GNT_B);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_gnt_q <= GNT_B;
            gnt_q      <= GNT_A;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            sw_sel_q   <= '0;
            sw_dir_q   <= 1'b0;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            sw_sel_q   <= sw_sel_d;
            sw_dir_q   <= sw_dir_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            busy_q     <= busy_d;
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign sw_sel  = sw_sel_q;
    assign sw_dir  = sw_dir_q;
    assign bus_out = bus_out_q;
    assign bus_oe  = bus_oe_q;
    assign busy    = busy_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboarded bench: instance 0 (TURN_CYC=1) with a register-switch model, instance 1 (TURN_CYC=3).
module tb_reg_bus_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // instance 0 signals
    logic       rst_n;
    logic       a_req, a_wr, b_req, b_wr;
    logic [2:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_ack, b_ack, sw_dir, bus_oe, busy;
    logic [7:0] a_rdata, b_rdata, bus_out, bus_in;
    logic [2:0] sw_sel;

    // instance 1 signals (requester B unused)
    logic       t_a_req, t_a_wr;
    logic [2:0] t_a_addr;
    logic [7:0] t_a_wdata;
    logic       t_b_req = 1'b0, t_b_wr = 1'b0;
    logic [2:0] t_b_addr = 3'd0;
    logic [7:0] t_b_wdata = 8'd0;
    logic       t_a_ack, t_b_ack, t_sw_dir, t_bus_oe, t_busy;
    logic [7:0] t_a_rdata, t_b_rdata, t_bus_out, t_bus_in;
    logic [2:0] t_sw_sel;

    reg_bus_arbiter #(.DW(8), .AW(3), .TURN_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .sw_sel(sw_sel), .sw_dir(sw_dir), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in), .busy(busy)
    );

    reg_bus_arbiter #(.DW(8), .AW(3), .TURN_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .a_req(t_a_req), .a_wr(t_a_wr), .a_addr(t_a_addr), .a_wdata(t_a_wdata), .a_ack(t_a_ack), .a_rdata(t_a_rdata),
        .b_req(t_b_req), .b_wr(t_b_wr), .b_addr(t_b_addr), .b_wdata(t_b_wdata), .b_ack(t_b_ack), .b_rdata(t_b_rdata),
        .sw_sel(t_sw_sel), .sw_dir(t_sw_dir), .bus_out(t_bus_out), .bus_oe(t_bus_oe), .bus_in(t_bus_in), .busy(t_busy)
    );

    // Switch model for instance 0: 8 registers behind a bidirectional mux.
    localparam logic [7:0] INIT [8] = '{8'h11, 8'h22, 8'h5A, 8'h00, 8'h30, 8'hA5, 8'h66, 8'h77};
    logic [7:0] regs [8];
    logic       init_regs;
    always @(posedge clk) begin
        if (init_regs) begin
            for (int i = 0; i < 8; i++) regs[i] <= INIT[i];
        end else if (bus_oe && sw_dir) begin
            regs[sw_sel] <= bus_out;
        end
    end
    always_comb bus_in = bus_oe ? bus_out : (sw_dir ? 8'h00 : regs[sw_sel]);
    // Instance 1 reads a fixed pattern C0|sel.
    always_comb t_bus_in = t_bus_oe ? t_bus_out : (8'hC0 | {5'd0, t_sw_sel});

    typedef struct {
        bit         id;
        bit         wr;
        logic [2:0] addr;
        logic [7:0] data;
        int         lat;
        int         t0;
    } exp_t;

    exp_t q [2][$];
    int   since [2] = '{100, 100};
    logic prev_dir [2] = '{1'b0, 1'b0};
    localparam int TC [2] = '{1, 3};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int d, input logic aa, input logic ba, input logic [7:0] ar,
                       input logic [7:0] br, input logic oe, input logic [7:0] bo,
                       input logic [2:0] sel, input logic dir);
        exp_t e;
        if (aa && ba) chk("ack_overlap", 1, 0);
        if (aa || ba) begin
            if (q[d].size() == 0) chk("unexpected_ack", 1, 0);
            else begin
                e = q[d].pop_front();
                chk("grant_id", {31'd0, ba}, {31'd0, e.id});
                if (!e.wr) chk("rdata", e.id ? br : ar, e.data);
                if (e.lat >= 0) chk("latency", cyc - e.t0, e.lat);
            end
        end
        if (dir !== prev_dir[d]) since[d] = 0;
        else if (since[d] < 100) since[d]++;
        prev_dir[d] = dir;
        if (oe) begin
            chk("oe_needs_dir1", {31'd0, dir}, 1);
            chk("oe_turn_gap", {31'd0, since[d] >= TC[d]}, 1);
            if (q[d].size() == 0) chk("oe_without_txn", 1, 0);
            else begin
                chk("oe_is_write", {31'd0, q[d][0].wr}, 1);
                chk("bus_out", bo, q[d][0].data);
                chk("xfer_sel", sel, q[d][0].addr);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, a_ack, b_ack, a_rdata, b_rdata, bus_oe, bus_out, sw_sel, sw_dir);
        mon(1, t_a_ack, 1'b0, t_a_rdata, 8'h00, t_bus_oe, t_bus_out, t_sw_sel, t_sw_dir);
    end

    task automatic push(input int d, input bit id, input bit wr, input logic [2:0] addr,
                        input logic [7:0] data, input int lat);
        exp_t e;
        e = '{id, wr, addr, data, lat, cyc};
        q[d].push_back(e);
    endtask

    task automatic drive(input int d, input bit id, input bit wr, input logic [2:0] addr, input logic [7:0] wd);
        bit got;
        got = 1'b0;
        if (d == 1)  begin t_a_req = 1; t_a_wr = wr; t_a_addr = addr; t_a_wdata = wd; end
        else if (id) begin b_req = 1; b_wr = wr; b_addr = addr; b_wdata = wd; end
        else         begin a_req = 1; a_wr = wr; a_addr = addr; a_wdata = wd; end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = (d == 1) ? t_a_ack : (id ? b_ack : a_ack);
        end
        if (d == 1)  t_a_req = 0;
        else if (id) b_req = 0;
        else         a_req = 0;
        if (!got) chk("ack_timeout", 0, 1);
    endtask

    task automatic txn(input int d, input bit id, input bit wr, input logic [2:0] addr,
                       input logic [7:0] data, input int lat);
        @(negedge clk);
        push(d, id, wr, addr, data, lat);
        drive(d, id, wr, addr, data);
    endtask

    localparam logic [2:0] CA_ADDR [4] = '{3'd1, 3'd2, 3'd5, 3'd0};
    localparam logic [7:0] CA_EXP  [4] = '{8'h22, 8'h5A, 8'hA5, 8'h11};
    localparam logic [2:0] CB_ADDR [4] = '{3'd6, 3'd0, 3'd4, 3'd7};
    localparam logic [7:0] CB_EXP  [4] = '{8'h66, 8'h11, 8'h30, 8'h77};

    initial begin
        bit seen;
        rst_n = 0; init_regs = 1;
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_addr = 0; b_wdata = 0;
        t_a_req = 0; t_a_wr = 0; t_a_addr = 0; t_a_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_a_ack", {31'd0, a_ack}, 0);
        chk("rst_b_ack", {31'd0, b_ack}, 0);
        chk("rst_a_rdata", a_rdata, 0);
        chk("rst_b_rdata", b_rdata, 0);
        chk("rst_sw_sel", sw_sel, 0);
        chk("rst_sw_dir", {31'd0, sw_dir}, 0);
        chk("rst_bus_oe", {31'd0, bus_oe}, 0);
        chk("rst_bus_out", bus_out, 0);
        chk("rst_t3_busy", {31'd0, t_busy}, 0);
        init_regs = 0; rst_n = 1;

        // write with turnaround, read with turnaround, same-direction reads, readback
        txn(0, 0, 1, 3'd3, 8'hFD, 4);
        txn(0, 1, 0, 3'd4, 8'h30, 4);
        txn(0, 0, 0, 3'd2, 8'h5A, 3);
        txn(0, 0, 0, 3'd5, 8'hA5, 3);
        txn(0, 0, 0, 3'd3, 8'hFD, 3);
        chk("b_rdata_hold", b_rdata, 8'h30);
        chk("idle_oe_low", {31'd0, bus_oe}, 0);

        // contention from a fresh reset: A then B each round
        @(negedge clk); rst_n = 0;
        repeat (2) @(negedge clk); rst_n = 1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clk);
            push(0, 0, 0, CA_ADDR[r], CA_EXP[r], 3);
            push(0, 1, 0, CB_ADDR[r], CB_EXP[r], 7);
            fork
                drive(0, 0, 0, CA_ADDR[r], 8'h00);
                drive(0, 1, 0, CB_ADDR[r], 8'h00);
            join
        end

        // reset during XFER of a write
        @(negedge clk);
        push(0, 0, 1, 3'd6, 8'h99, -1);
        a_req = 1; a_wr = 1; a_addr = 3'd6; a_wdata = 8'h99;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus_oe;
        end
        chk("xfer_reached", {31'd0, seen}, 1);
        rst_n = 0; a_req = 0;
        @(negedge clk);
        chk("abort_bus_oe", {31'd0, bus_oe}, 0);
        chk("abort_sw_sel", sw_sel, 0);
        chk("abort_sw_dir", {31'd0, sw_dir}, 0);
        chk("abort_no_ack", {31'd0, a_ack}, 0);
        chk("abort_busy", {31'd0, busy}, 0);
        chk("abort_a_rdata", a_rdata, 0);
        q[0].delete();
        @(negedge clk); rst_n = 1;
        txn(0, 0, 1, 3'd7, 8'h3C, 4);
        txn(0, 1, 0, 3'd7, 8'h3C, 4);

        // TURN_CYC=3 instance: read, write with 3-cycle turn, read with 3-cycle turn
        txn(1, 0, 0, 3'd2, 8'hC2, 3);
        txn(1, 0, 1, 3'd5, 8'h4B, 6);
        txn(1, 0, 0, 3'd1, 8'hC1, 6);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q[0].size() + q[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Sequencing controller for the 8-entry register switch with bidirectional mux.
- Two requesters (A and B) share the switch's single `out` port. The controller arbitrates between them round-robin and drives the switch's `sel`/`dir`.
- It drives the `out` side of the bus for writes and samples it for reads, inserting a bus-turnaround gap whenever the transfer direction changes so that the switch and the controller never drive the shared bus together.

Parameters:
- DW, 8, data width of registers and of the shared bus.
- AW, 3, register select width (2**AW registers).
- TURN_CYC, 1, idle cycles (oe low, no transfer) inserted when `dir` must change; legal range 1..7.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- a_req  input  1  requester A transaction request; held until a_ack.
- a_wr  input  1  A direction: 1 = write register, 0 = read register.
- a_addr  input  AW  A register index.
- a_wdata  input  DW  A write data.
- a_ack  output  1  one-cycle completion pulse to A.
- a_rdata  output  DW  A read data; valid when a_ack=1, held until A's next read completes.
- b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata  same as the A ports, for requester B.
- sw_sel  output  AW  to switch `sel`.
- sw_dir  output  1  to switch `dir`: 0 = register→out (read), 1 = out→register (write).
- bus_out  output  DW  data the controller places on the `out` bus.
- bus_oe  output  1  tristate enable for bus_out (top level: out = bus_oe ? bus_out : Z).
- bus_in  input  DW  sampled value of the `out` bus.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset is synchronous, active-low, and uses clk. On rst_n=0 at a rising edge:
  - state = IDLE.
  - sw_sel = 0, sw_dir = 0, bus_oe = 0, bus_out = 0.
  - a_ack = b_ack = 0, a_rdata = b_rdata = 0, busy = 0.
  - last_gnt = B, so A wins the first tie.
  - turnaround counter = 0.
- All outputs are registered.
- FSM states: IDLE, SETUP, TURN, XFER, ACK.
  - IDLE:
    - If any req is high, grant and latch the winner's wr/addr/wdata, then go to SETUP.
    - If only one req is high, that requester wins.
    - If both are high, the requester other than last_gnt wins, and last_gnt is updated.
  - SETUP (1 cycle):
    - sw_sel = addr, bus_oe = 0.
    - If the latched wr equals the current sw_dir, go to XFER.
    - Otherwise load the counter with TURN_CYC and go to TURN; sw_dir keeps its old value during SETUP.
  - TURN:
    - sw_dir is updated to wr on entry. bus_oe = 0.
    - The counter decrements each cycle; go to XFER when it reaches 1. TURN lasts exactly TURN_CYC cycles.
  - XFER (1 cycle):
    - Write: bus_out = wdata, bus_oe = 1.
    - Read: bus_oe = 0, and bus_in is captured into the granted requester's rdata at the closing edge of XFER.
  - ACK (1 cycle):
    - The granted requester's ack = 1 and bus_oe = 0; then go to IDLE.
    - The other requester's ack stays 0.
- Latency, measured from the edge at which IDLE samples req=1 to the ack-high cycle:
  - 3 cycles with no direction change.
  - 3 + TURN_CYC cycles with a direction change.
- Requester rules:
  - Hold req, wr, addr and wdata stable until ack is seen.
  - Deassert req at the same edge ack is sampled.
  - A req still high in IDLE after ack counts as a new transaction.
- Fields are latched at grant, so changes to inputs after grant do not affect the transaction in flight.
- Between transactions, sw_sel and sw_dir hold their last values and bus_oe = 0.
- Bus exclusivity: bus_oe = 1 only in XFER with sw_dir = 1. bus_oe is never high in the same cycle as an sw_dir change or in the cycle after one.
- Reset mid-transaction: abort immediately, with no ack and no rdata update; bus_oe drops at that edge.
- A req arriving during a transaction waits; round-robin guarantees service within one transaction of the competing requester.

Test Plan:
- Single A write: a_req=1, a_wr=1, a_addr=3, a_wdata=8'hFD from reset (sw_dir=0) → SETUP, TURN 1 cycle (sw_dir→1), XFER with sw_sel=3, bus_oe=1, bus_out=FD; a_ack at cycle 4; register 3 reads back FD.
- B read after write: b_req, b_wr=0, b_addr=4, register 4 preloaded with 8'h30 → turnaround 1 cycle, sw_dir=0, b_rdata=30 with b_ack at cycle 4; bus_oe never 1.
- Same-direction back-to-back: two A reads, addr 2 then 5 → each acked 3 cycles after its request; no TURN state; rdata correct for each.
- Contention: a_req and b_req rise in the same cycle, repeated 4 times → grant order A, B, A, B; exactly one ack per transaction; no ack overlap.
- Reset mid-op: rst_n=0 during XFER of a write → next cycle bus_oe=0, sw_sel=0, sw_dir=0, no ack; a fresh request after release completes normally.
- TURN_CYC=3 build: read then write → bus_oe stays low for 3 cycles after the sw_dir change; write acked 6 cycles after its request.
